// File: rtl/fft_mem_bridge_if.sv
// fft_mem_bridge_if
//   Bundles the FFT accelerator read/write handshake and the shared
//   single-beat word memory port used by fft_mem_bridge.
//
//   Handshake semantics, in one place:
//     Accelerator side: while acc_read_enable (acc_write_enable) is high the
//     accelerator owns a session. acc_read_ready[0] (acc_write_ready[0])
//     rises when the current word is delivered (committed) and stays high
//     until the accelerator pulses acc_finish_read (acc_finish_write) for one
//     cycle. In that same cycle the address and data of the next word must
//     already be present. Dropping the enable ends the session.
//     Memory side: mem_req with mem_we/mem_addr/mem_wdata is held stable
//     until the cycle in which mem_gnt is high. A request is accepted in that
//     cycle. A read returns mem_rdata with mem_rvalid one or more cycles after
//     its grant.
//
//   Modports:
//     slave  - the bridge: responder to the accelerator and master of memory
//     master - the environment: the accelerator plus the memory
interface fft_mem_bridge_if #(
   parameter int DATA_W = 64,
   parameter int MEM_AW = 32
);
   logic              acc_read_enable;
   logic              acc_finish_read;
   logic [63:0]       acc_read_addr;
   logic [63:0]       acc_read_ready;
   logic [DATA_W-1:0] acc_read_data;
   logic              acc_write_enable;
   logic              acc_finish_write;
   logic [63:0]       acc_write_addr;
   logic [DATA_W-1:0] acc_write_data;
   logic [63:0]       acc_write_ready;
   logic              mem_req;
   logic              mem_we;
   logic [MEM_AW-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  acc_read_enable, acc_finish_read, acc_read_addr,
      output acc_read_ready, acc_read_data,
      input  acc_write_enable, acc_finish_write, acc_write_addr, acc_write_data,
      output acc_write_ready,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport master (
      output acc_read_enable, acc_finish_read, acc_read_addr,
      input  acc_read_ready, acc_read_data,
      output acc_write_enable, acc_finish_write, acc_write_addr, acc_write_data,
      input  acc_write_ready,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/fft_mem_bridge.sv
// fft_mem_bridge
//   Memory-side responder for the FFT accelerator. Each accelerator word
//   transfer becomes one single-beat req/gnt(/rvalid) transaction on a shared
//   word memory port. Reads take priority over writes when both sessions
//   start together.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   bus (slave)     accelerator handshake + memory port (fft_mem_bridge_if)
//   align_err       sticky: some request had a byte address not word aligned
//   state_dbg       current FSM state: 0 IDLE, 1 RD_REQ, 2 RD_WAIT,
//                   3 RD_HOLD, 4 WR_REQ, 5 WR_HOLD
//   stat_rd_beats   (BRIDGE_STATS_EN) granted reads, saturating
//   stat_wr_beats   (BRIDGE_STATS_EN) granted writes, saturating
//   stat_stall_cyc  (BRIDGE_STATS_EN) cycles waiting on gnt/rvalid, saturating
//
// Optional build macro: BRIDGE_STATS_EN adds the three stat_* counters.
module fft_mem_bridge #(
   parameter int DATA_W     = 64,
   parameter int MEM_AW     = 32,
   parameter int WORD_SHIFT = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   fft_mem_bridge_if.slave       bus,
   output logic                  align_err,
   output logic [2:0]            state_dbg
`ifdef BRIDGE_STATS_EN
   ,
   output logic [31:0]           stat_rd_beats,
   output logic [31:0]           stat_wr_beats,
   output logic [31:0]           stat_stall_cyc
`endif
);

   localparam int HI = MEM_AW + WORD_SHIFT;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_REQ  = 3'd1,
      S_RD_WAIT = 3'd2,
      S_RD_HOLD = 3'd3,
      S_WR_REQ  = 3'd4,
      S_WR_HOLD = 3'd5
   } state_t;

   state_t            state;
   logic [MEM_AW-1:0] waddr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic              rd_ready_q;
   logic              wr_ready_q;
   logic              req_q;
   logic              we_q;
   logic              drop_q;   // read session ended while a read was in flight

   logic [MEM_AW-1:0] rd_word;
   logic [MEM_AW-1:0] wr_word;
   logic              rd_mis;
   logic              wr_mis;
   logic              unused_addr_bits;

   // Upper address bits beyond the word address space are dropped, so the
   // word address wraps modulo 2^MEM_AW.
   assign rd_word = bus.acc_read_addr[HI-1:WORD_SHIFT];
   assign wr_word = bus.acc_write_addr[HI-1:WORD_SHIFT];
   assign rd_mis  = |bus.acc_read_addr[WORD_SHIFT-1:0];
   assign wr_mis  = |bus.acc_write_addr[WORD_SHIFT-1:0];
   assign unused_addr_bits = ^{bus.acc_read_addr[63:HI], bus.acc_write_addr[63:HI]};

   assign bus.acc_read_ready  = {63'd0, rd_ready_q};
   assign bus.acc_write_ready = {63'd0, wr_ready_q};
   assign bus.acc_read_data   = rdata_q;
   assign bus.mem_req         = req_q;
   assign bus.mem_we          = we_q;
   assign bus.mem_addr        = waddr_q;
   assign bus.mem_wdata       = wdata_q;
   assign state_dbg           = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         waddr_q    <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         rd_ready_q <= 1'b0;
         wr_ready_q <= 1'b0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         drop_q     <= 1'b0;
         align_err  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.acc_read_enable) begin
                  waddr_q <= rd_word;
                  req_q   <= 1'b1;
                  we_q    <= 1'b0;
                  drop_q  <= 1'b0;
                  if (rd_mis) align_err <= 1'b1;
                  state   <= S_RD_REQ;
               end else if (bus.acc_write_enable) begin
                  waddr_q <= wr_word;
                  wdata_q <= bus.acc_write_data;
                  req_q   <= 1'b1;
                  we_q    <= 1'b1;
                  if (wr_mis) align_err <= 1'b1;
                  state   <= S_WR_REQ;
               end
            end
            S_RD_REQ: begin
               // The request cannot be withdrawn once raised; remember that
               // the session ended so the returning data is thrown away.
               if (!bus.acc_read_enable) drop_q <= 1'b1;
               if (bus.mem_gnt) begin
                  req_q <= 1'b0;
                  state <= S_RD_WAIT;
               end
            end
            S_RD_WAIT: begin
               if (bus.mem_rvalid) begin
                  if (drop_q || !bus.acc_read_enable) begin
                     state <= S_IDLE;
                  end else begin
                     rdata_q    <= bus.mem_rdata;
                     rd_ready_q <= 1'b1;
                     state      <= S_RD_HOLD;
                  end
               end else if (!bus.acc_read_enable) begin
                  drop_q <= 1'b1;
               end
            end
            S_RD_HOLD: begin
               if (bus.acc_finish_read) begin
                  rd_ready_q <= 1'b0;
                  waddr_q    <= rd_word;
                  req_q      <= 1'b1;
                  we_q       <= 1'b0;
                  drop_q     <= 1'b0;
                  if (rd_mis) align_err <= 1'b1;
                  state      <= S_RD_REQ;
               end else if (!bus.acc_read_enable) begin
                  rd_ready_q <= 1'b0;
                  state      <= S_IDLE;
               end
            end
            S_WR_REQ: begin
               if (bus.mem_gnt) begin
                  req_q <= 1'b0;
                  we_q  <= 1'b0;
                  // A write whose session already ended still commits, but
                  // nobody is waiting for its ready.
                  if (bus.acc_write_enable) begin
                     wr_ready_q <= 1'b1;
                     state      <= S_WR_HOLD;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end
            S_WR_HOLD: begin
               if (bus.acc_finish_write) begin
                  wr_ready_q <= 1'b0;
                  waddr_q    <= wr_word;
                  wdata_q    <= bus.acc_write_data;
                  req_q      <= 1'b1;
                  we_q       <= 1'b1;
                  if (wr_mis) align_err <= 1'b1;
                  state      <= S_WR_REQ;
               end else if (!bus.acc_write_enable) begin
                  wr_ready_q <= 1'b0;
                  state      <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef BRIDGE_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_rd_beats  <= '0;
         stat_wr_beats  <= '0;
         stat_stall_cyc <= '0;
      end else begin
         if (state == S_RD_REQ && bus.mem_gnt && stat_rd_beats != 32'hFFFF_FFFF)
            stat_rd_beats <= stat_rd_beats + 32'd1;
         if (state == S_WR_REQ && bus.mem_gnt && stat_wr_beats != 32'hFFFF_FFFF)
            stat_wr_beats <= stat_wr_beats + 32'd1;
         if ((((state == S_RD_REQ) || (state == S_WR_REQ)) && !bus.mem_gnt) ||
             ((state == S_RD_WAIT) && !bus.mem_rvalid)) begin
            if (stat_stall_cyc != 32'hFFFF_FFFF)
               stat_stall_cyc <= stat_stall_cyc + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fft_mem_bridge.sv
// tb_fft_mem_bridge
//   Drives accelerator read/write sessions against fft_mem_bridge, with a
//   memory responder whose grant and read latencies are programmable.
//   Expected memory accesses and read data come from a word-level reference
//   model (byte address / 8, modulo 2^32; writes update a reference memory).
module tb_fft_mem_bridge;
   localparam int W        = 97;   // {we, word addr[31:0], wdata[63:0]}
   localparam int ST_IDLE  = 0;
   localparam int ST_RD_WT = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic       align_err;
   logic [2:0] state_dbg;
`ifdef BRIDGE_STATS_EN
   logic [31:0] stat_rd_beats, stat_wr_beats, stat_stall_cyc;
`endif

   fft_mem_bridge_if #(.DATA_W(64), .MEM_AW(32)) bus ();

   fft_mem_bridge #(.DATA_W(64), .MEM_AW(32), .WORD_SHIFT(3)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .align_err (align_err),
      .state_dbg (state_dbg)
`ifdef BRIDGE_STATS_EN
      ,
      .stat_rd_beats  (stat_rd_beats),
      .stat_wr_beats  (stat_wr_beats),
      .stat_stall_cyc (stat_stall_cyc)
`endif
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int n_tests = 0;
   int n_fail  = 0;
   logic [W-1:0]  exp_q[$];
   logic [W-1:0]  obs_q[$];
   logic [63:0]   ref_mem   [logic [31:0]];
   logic [63:0]   mem_store [logic [31:0]];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] pattern(input logic [31:0] a);
      return {a ^ 32'hC0DE_0000, ~a};
   endfunction

   function automatic logic [31:0] word_of(input logic [63:0] byte_addr);
      return 32'(byte_addr >> 3);
   endfunction

   function automatic logic [63:0] ref_read(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return pattern(a);
   endfunction

   // ---------------- memory responder ----------------
   int          gnt_delay    = 0;
   int          rv_delay     = 1;
   int          req_cnt      = 0;
   int          last_req_len = 0;
   bit          rv_pend      = 0;
   int          rv_cnt       = 0;
   logic [63:0] rv_data      = '0;
   int          rd_gnts      = 0;
   int          wr_gnts      = 0;

   always @(posedge clk) begin
      #2;
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
      if (reset) begin
         rd_gnts = 0;
         wr_gnts = 0;
      end
      if (rv_pend) begin
         rv_cnt--;
         if (rv_cnt == 0) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = rv_data;
            rv_pend        = 0;
         end
      end
      if (bus.mem_req === 1'b1) begin
         if (req_cnt == gnt_delay) begin
            bus.mem_gnt  = 1'b1;
            last_req_len = req_cnt + 1;
            req_cnt      = 0;
            obs_q.push_back({bus.mem_we, bus.mem_addr, bus.mem_we ? bus.mem_wdata : 64'h0});
            if (bus.mem_we) begin
               mem_store[bus.mem_addr] = bus.mem_wdata;
               wr_gnts++;
            end else begin
               rv_pend = 1;
               rv_cnt  = rv_delay;
               rv_data = mem_store.exists(bus.mem_addr) ? mem_store[bus.mem_addr]
                                                        : pattern(bus.mem_addr);
               rd_gnts++;
            end
         end else begin
            req_cnt++;
         end
      end else begin
         req_cnt = 0;
      end
   end

   // ---------------- ready pulse monitor ----------------
   int   rd_pulses = 0;
   int   wr_pulses = 0;
   logic rd_prev   = 1'b0;
   logic wr_prev   = 1'b0;

   always @(negedge clk) begin
      if (bus.acc_read_ready[0] && !rd_prev) rd_pulses++;
      if (bus.acc_write_ready[0] && !wr_prev) wr_pulses++;
      rd_prev = bus.acc_read_ready[0];
      wr_prev = bus.acc_write_ready[0];
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain_sb();
      while (exp_q.size() > 0) begin
         logic [W-1:0] e;
         logic [W-1:0] o;
         e = exp_q.pop_front();
         if (obs_q.size() == 0) begin
            check("access_missing", 64'(obs_q.size()), 64'd1);
         end else begin
            o = obs_q.pop_front();
            check("acc_we",    64'(o[96]),    64'(e[96]));
            check("acc_addr",  64'(o[95:64]), 64'(e[95:64]));
            check("acc_wdata", o[63:0],       e[63:0]);
         end
      end
   endtask

   task automatic wait_ready(input bit is_rd, output int cycles);
      cycles = 0;
      while (!(is_rd ? bus.acc_read_ready[0] : bus.acc_write_ready[0]) && cycles < 200) begin
         tick();
         cycles++;
      end
      if (cycles >= 200) begin
         if (is_rd) check("rd_ready_timeout", bus.acc_read_ready, 64'd1);
         else       check("wr_ready_timeout", bus.acc_write_ready, 64'd1);
      end
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      bus.acc_read_enable  = 1'b0;
      bus.acc_write_enable = 1'b0;
      bus.acc_finish_read  = 1'b0;
      bus.acc_finish_write = 1'b0;
      tick(2);
      reset = 1'b0;
   endtask

   task automatic read_burst(input logic [63:0] base, input int n,
                             input logic [63:0] stride, input int exp_lat);
      int          lat;
      int          p0;
      logic [63:0] a;
      p0 = rd_pulses;
      a  = base;
      bus.acc_read_addr   = a;
      bus.acc_read_enable = 1'b1;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({1'b0, word_of(a), 64'h0});
         wait_ready(1'b1, lat);
         if (i == 0 && exp_lat >= 0) check("rd_latency", 64'(lat), 64'(exp_lat));
         check("rd_data", bus.acc_read_data, ref_read(word_of(a)));
         drain_sb();
         a = a + stride;
         if (i < n - 1) begin
            bus.acc_finish_read = 1'b1;
            bus.acc_read_addr   = a;
            tick();
            bus.acc_finish_read = 1'b0;
            check("rd_ready_after_finish", bus.acc_read_ready, 64'd0);
         end else begin
            bus.acc_read_enable = 1'b0;
            tick();
            check("rd_ready_after_drop", bus.acc_read_ready, 64'd0);
            check("rd_idle", 64'(state_dbg), 64'(ST_IDLE));
         end
      end
      check("rd_pulse_count", 64'(rd_pulses - p0), 64'(n));
   endtask

   task automatic write_burst(input logic [63:0] base, input int n,
                              input logic [63:0] data0, input int exp_lat);
      int          lat;
      int          p0;
      logic [63:0] a;
      logic [63:0] d;
      p0 = wr_pulses;
      a  = base;
      d  = data0;
      bus.acc_write_addr   = a;
      bus.acc_write_data   = d;
      bus.acc_write_enable = 1'b1;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({1'b1, word_of(a), d});
         wait_ready(1'b0, lat);
         if (i == 0 && exp_lat >= 0) check("wr_latency", 64'(lat), 64'(exp_lat));
         drain_sb();
         ref_mem[word_of(a)] = d;
         a = a + 64'd8;
         d = d + 64'd1;
         if (i < n - 1) begin
            bus.acc_finish_write = 1'b1;
            bus.acc_write_addr   = a;
            bus.acc_write_data   = d;
            tick();
            bus.acc_finish_write = 1'b0;
            check("wr_ready_after_finish", bus.acc_write_ready, 64'd0);
         end else begin
            bus.acc_write_enable = 1'b0;
            tick();
            check("wr_ready_after_drop", bus.acc_write_ready, 64'd0);
            check("wr_idle", 64'(state_dbg), 64'(ST_IDLE));
         end
      end
      check("wr_pulse_count", 64'(wr_pulses - p0), 64'(n));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rd_ready"}, bus.acc_read_ready, 64'd0);
      check({tag, "_rd_data"},  bus.acc_read_data,  64'd0);
      check({tag, "_wr_ready"}, bus.acc_write_ready, 64'd0);
      check({tag, "_mem_req"},  64'(bus.mem_req),   64'd0);
      check({tag, "_mem_we"},   64'(bus.mem_we),    64'd0);
      check({tag, "_mem_addr"}, 64'(bus.mem_addr),  64'd0);
      check({tag, "_mem_wdata"}, bus.mem_wdata,     64'd0);
      check({tag, "_align"},    64'(align_err),     64'd0);
      check({tag, "_state"},    64'(state_dbg),     64'(ST_IDLE));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int          cyc;
      int          p0;
      logic [63:0] base;
      logic [63:0] data;
      int          n;

      reset = 1'b1;
      bus.acc_read_enable  = 1'b0;
      bus.acc_finish_read  = 1'b0;
      bus.acc_read_addr    = '0;
      bus.acc_write_enable = 1'b0;
      bus.acc_finish_write = 1'b0;
      bus.acc_write_addr   = '0;
      bus.acc_write_data   = '0;
      bus.mem_gnt          = 1'b0;
      bus.mem_rvalid       = 1'b0;
      bus.mem_rdata        = '0;
      tick(3);
      check_all_zero("reset");
      reset = 1'b0;
      tick();

      // Four-word read, stride 8, minimum latency.
      read_burst(64'h100, 4, 64'd8, 3);
      check("align_clean", 64'(align_err), 64'd0);

      // Three-word write.
      write_burst(64'h200, 3, 64'hA5A5_0000, 2);
      tick(2);

      // Slow memory: grant after 5 waiting cycles, data 3 cycles later.
      gnt_delay = 5;
      rv_delay  = 3;
      read_burst(64'h200, 1, 64'd8, -1);
      check("req_hold_len", 64'(last_req_len), 64'd6);
      gnt_delay = 0;
      rv_delay  = 1;

      // Read and write sessions start together: read is served first.
      bus.acc_write_addr   = 64'h280;
      bus.acc_write_data   = 64'h1234_5678_9ABC_DEF0;
      bus.acc_write_enable = 1'b1;
      read_burst(64'h140, 2, 64'd8, 3);
      write_burst(64'h280, 1, 64'h1234_5678_9ABC_DEF0, 2);

      // Upper byte-address bits wrap away.
      read_burst(64'h0000_0008_0000_0010, 1, 64'd8, -1);

      // Misaligned address: sticky error, access to truncated word.
      read_burst(64'h104, 1, 64'd8, -1);
      check("align_set", 64'(align_err), 64'd1);
      write_burst(64'h300, 1, 64'hCAFE, -1);
      check("align_sticky", 64'(align_err), 64'd1);
      apply_reset();
      tick();
      check("align_reset", 64'(align_err), 64'd0);

      // Read session dropped while the request is outstanding.
      gnt_delay = 3;
      p0 = rd_pulses;
      bus.acc_read_addr   = 64'h400;
      bus.acc_read_enable = 1'b1;
      exp_q.push_back({1'b0, word_of(64'h400), 64'h0});
      tick(2);
      bus.acc_read_enable = 1'b0;
      cyc = 0;
      while (state_dbg != 3'(ST_IDLE) && cyc < 50) begin
         tick();
         cyc++;
      end
      check("drop_idle", 64'(state_dbg), 64'(ST_IDLE));
      tick(2);
      check("drop_no_ready", 64'(rd_pulses - p0), 64'd0);
      drain_sb();
      gnt_delay = 0;

      // Reset while waiting for read data; the late rvalid must be ignored.
      rv_delay = 3;
      p0 = rd_pulses;
      bus.acc_read_addr   = 64'h180;
      bus.acc_read_enable = 1'b1;
      exp_q.push_back({1'b0, word_of(64'h180), 64'h0});
      cyc = 0;
      while (state_dbg != 3'(ST_RD_WT) && cyc < 20) begin
         tick();
         cyc++;
      end
      check("reached_rd_wait", 64'(state_dbg), 64'(ST_RD_WT));
      reset = 1'b1;
      bus.acc_read_enable = 1'b0;
      tick();
      reset = 1'b0;
      tick(5);
      check_all_zero("mid_reset");
      check("mid_reset_no_ready", 64'(rd_pulses - p0), 64'd0);
      drain_sb();
      rv_delay = 1;

      // Randomized sessions with random memory latencies.
      for (int it = 0; it < 10; it++) begin
         gnt_delay = $urandom_range(0, 3);
         rv_delay  = $urandom_range(1, 3);
         base      = 64'h1000 + 64'($urandom_range(0, 255)) * 64'd8;
         n         = $urandom_range(1, 4);
         if ($urandom_range(0, 1) == 1) begin
            data = {$urandom, $urandom};
            write_burst(base, n, data, -1);
            read_burst(base, n, 64'd8, -1);
         end else begin
            read_burst(base, n, 64'd8, -1);
         end
         tick($urandom_range(0, 2));
      end

      tick(4);
      check("no_extra_access", 64'(obs_q.size()), 64'd0);
`ifdef BRIDGE_STATS_EN
      check("stat_rd_beats", 64'(stat_rd_beats), 64'(rd_gnts));
      check("stat_wr_beats", 64'(stat_wr_beats), 64'(wr_gnts));
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
